t_flip_flop: RTL and testbench
==============================

Name: t_flip_flop

Overview:
- Parameterised bank of WIDTH independent toggle (T-type) flip-flops sharing one clock and one reset.
- Each bit of q inverts on a rising clock edge when its t bit is 1, and holds otherwise; qbar is the bitwise complement of q.
- Used as a divide-by-2 element, parity/phase tracker, or building block for ripple/synchronous counters in datapath and control logic.

Parameters:
- WIDTH, 1, number of independent toggle flip-flops (>= 1).
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset, bit-for-bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high; forces q = RESET_VAL immediately.
- t  input  WIDTH  per-bit toggle enable, sampled on the rising clk edge.
- q  output  WIDTH  registered flip-flop state.
- qbar  output  WIDTH  complement of q; combinational, equals ~q at all times.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: while rst = 1, q = RESET_VAL and qbar = ~RESET_VAL, regardless of clk and t.
  - Assertion takes effect without waiting for a clock edge.
  - t is ignored for the whole reset period.
- Reset release: the first rising edge with rst = 0 evaluates t normally; no extra dead cycle.
- Normal operation, per bit i, at each rising clk edge with rst = 0:
  - t[i] = 1 -> q[i] <= ~q[i].
  - t[i] = 0 -> q[i] <= q[i].
- Latency: one cycle; q reflects the toggle immediately after the sampling edge.
  - t must be stable around the rising edge; changes between edges have no effect.
- Bits are fully independent; any mix of t bits may be high in the same cycle.
- Reset mid-operation: rst asserted between edges clears q at once.
  - If rst and a clock edge coincide, reset wins.
- qbar is never registered separately; it must never disagree with q, including during reset.
- No X propagation from an unknown t while in reset: q stays RESET_VAL.

Optional Feature:
- Macro: TFF_LOAD_EN.
- Defined:
  - Adds input ld (1 bit) and input d (WIDTH bits).
  - At a rising edge with rst = 0 and ld = 1: q <= d, and t is ignored that cycle.
  - With ld = 0, behaviour is the normal toggle rule.
  - Reset still overrides ld.
- Not defined: ld and d ports do not exist; behaviour is exactly as above.

Test Plan:
- Reset hold (WIDTH=1): rst=1 for 50 cycles, t random each cycle -> q=0 and qbar=1 checked after every edge.
- Toggle sequence: release rst, then t=1,1,0,1,0,0,1 on successive edges -> q=1,0,0,1,1,1,0.
  - qbar is the complement at every check.
- Random regression: 1000 cycles of random t after reset; a reference model flips expected q when t=1 -> q matches on every cycle, with zero mismatches.
- Async reset: with q=1, raise rst midway between edges -> q=0 before the next rising edge.
  - Releasing rst with t=1 gives q=1 after the first edge.
- Multi-bit (WIDTH=4, RESET_VAL=4'b1010): after reset q=1010; t=0011 -> q=1001; t=1111 -> q=0110; t=0000 -> q=0110.
- TFF_LOAD_EN build: ld=1, d=4'b0101, t=1111 -> q=0101; next edge ld=0, t=0001 -> q=0100.

Source files
------------

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent toggle flip-flops with asynchronous active-high reset.
// Optional parallel load enabled by defining TFF_LOAD_EN (adds ld and d ports).
module t_flip_flop #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
`ifdef TFF_LOAD_EN
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

`ifdef TFF_LOAD_EN
  // Load takes priority over toggle; reset still overrides both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (ld) begin
      q <= d;
    end else begin
      q <= q ^ t;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else begin
      q <= q ^ t;
    end
  end
`endif

  // Derived from q so the two can never disagree, even during reset.
  assign qbar = ~q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Self-checking bench for t_flip_flop: single-bit and 4-bit instances,
// expected values queued when stimulus is driven and compared after the edge.
module tb_t_flip_flop;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, t1, q1, qb1;
  logic       rst4;
  logic [3:0] t4, q4, qb4;
`ifdef TFF_LOAD_EN
  logic       ld1, d1, ld4;
  logic [3:0] d4;
`endif

  int total = 0;
  int bad   = 0;

  logic       sb1[$];
  logic [3:0] sb4[$];
  logic       m1;
  logic [3:0] m4;

  t_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk  (clk),
    .rst  (rst1),
    .t    (t1),
`ifdef TFF_LOAD_EN
    .ld   (ld1),
    .d    (d1),
`endif
    .q    (q1),
    .qbar (qb1)
  );

  t_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .clk  (clk),
    .rst  (rst4),
    .t    (t4),
`ifdef TFF_LOAD_EN
    .ld   (ld4),
    .d    (d4),
`endif
    .q    (q4),
    .qbar (qb4)
  );

  task automatic test_reset();
    logic e;
    @(negedge clk);
    rst1 = 1'b1;
    t1   = 1'b1;
    #1;
    total++;
    if (q1 !== 1'b0 || qb1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_assert q=%b qbar=%b expected q=0 qbar=1", q1, qb1);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      t1 = 1'($urandom_range(0, 1));
      sb1.push_back(1'b0);
      @(posedge clk);
      #1;
      e = sb1.pop_front();
      total++;
      if (q1 !== e || qb1 !== ~e) begin
        bad++;
        $display("FAIL reset_hold cycle=%0d q=%b qbar=%b expected q=%b qbar=%b", i, q1, qb1, e, ~e);
      end
    end
  endtask

  task automatic test_toggle_seq();
    logic tv[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic ev[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst1 = 1'b0;
      t1   = tv[i];
      sb1.push_back(ev[i]);
      @(posedge clk);
      #1;
      e = sb1.pop_front();
      total++;
      if (q1 !== e || qb1 !== ~e) begin
        bad++;
        $display("FAIL toggle_seq step=%0d q=%b qbar=%b expected q=%b qbar=%b", i, q1, qb1, e, ~e);
      end
    end
    m1 = ev[6];
  endtask

  task automatic test_random();
    logic e;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      t1 = 1'($urandom_range(0, 1));
      if (t1) m1 = ~m1;
      sb1.push_back(m1);
      @(posedge clk);
      #1;
      e = sb1.pop_front();
      total++;
      if (q1 !== e || qb1 !== ~e) begin
        bad++;
        $display("FAIL random cycle=%0d q=%b qbar=%b expected q=%b qbar=%b", i, q1, qb1, e, ~e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic e;
    @(negedge clk);
    t1 = ~m1;
    sb1.push_back(1'b1);
    @(posedge clk);
    #1;
    e = sb1.pop_front();
    total++;
    if (q1 !== e) begin
      bad++;
      $display("FAIL async_setup q=%b expected %b", q1, e);
    end
    @(negedge clk);
    t1 = 1'b1;
    #2;
    rst1 = 1'b1;
    #1;
    total++;
    if (q1 !== 1'b0 || qb1 !== 1'b1) begin
      bad++;
      $display("FAIL async_mid_cycle q=%b qbar=%b expected q=0 qbar=1", q1, qb1);
    end
    sb1.push_back(1'b0);
    @(posedge clk);
    #1;
    e = sb1.pop_front();
    total++;
    if (q1 !== e) begin
      bad++;
      $display("FAIL async_hold_edge q=%b expected %b", q1, e);
    end
    @(negedge clk);
    rst1 = 1'b0;
    t1   = 1'b1;
    sb1.push_back(1'b1);
    @(posedge clk);
    #1;
    e = sb1.pop_front();
    total++;
    if (q1 !== e || qb1 !== ~e) begin
      bad++;
      $display("FAIL async_release q=%b qbar=%b expected q=%b qbar=%b", q1, qb1, e, ~e);
    end
    m1 = 1'b1;
  endtask

  task automatic test_multibit();
    logic [3:0] tv[3] = '{4'b0011, 4'b1111, 4'b0000};
    logic [3:0] ev[3] = '{4'b1001, 4'b0110, 4'b0110};
    logic [3:0] e;
    @(negedge clk);
    rst4 = 1'b1;
    t4   = 4'b1111;
    #1;
    total++;
    if (q4 !== 4'b1010 || qb4 !== 4'b0101) begin
      bad++;
      $display("FAIL multibit_reset q=%b qbar=%b expected q=1010 qbar=0101", q4, qb4);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst4 = 1'b0;
      t4   = tv[i];
      sb4.push_back(ev[i]);
      @(posedge clk);
      #1;
      e = sb4.pop_front();
      total++;
      if (q4 !== e || qb4 !== ~e) begin
        bad++;
        $display("FAIL multibit step=%0d q=%b qbar=%b expected q=%b qbar=%b", i, q4, qb4, e, ~e);
      end
    end
    m4 = 4'b0110;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      t4 = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) if (t4[b]) m4[b] = ~m4[b];
      sb4.push_back(m4);
      @(posedge clk);
      #1;
      e = sb4.pop_front();
      total++;
      if (q4 !== e || qb4 !== ~e) begin
        bad++;
        $display("FAIL multibit_random cycle=%0d q=%b expected %b", i, q4, e);
      end
    end
  endtask

  task automatic test_reset_coincide();
    @(negedge clk);
    t4 = ~(m4 ^ 4'b1010);
    @(posedge clk);
    rst4 = 1'b1;
    #1;
    total++;
    if (q4 !== 4'b1010 || qb4 !== 4'b0101) begin
      bad++;
      $display("FAIL reset_coincide q=%b qbar=%b expected q=1010 qbar=0101", q4, qb4);
    end
    @(negedge clk);
    rst4 = 1'b0;
    t4   = 4'b0000;
    m4   = 4'b1010;
  endtask

`ifdef TFF_LOAD_EN
  task automatic test_load();
    logic [3:0] e;
    @(negedge clk);
    ld4 = 1'b1;
    d4  = 4'b0101;
    t4  = 4'b1111;
    sb4.push_back(4'b0101);
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    total++;
    if (q4 !== e || qb4 !== ~e) begin
      bad++;
      $display("FAIL load q=%b expected %b", q4, e);
    end
    @(negedge clk);
    ld4 = 1'b0;
    t4  = 4'b0001;
    sb4.push_back(4'b0100);
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    total++;
    if (q4 !== e || qb4 !== ~e) begin
      bad++;
      $display("FAIL load_then_toggle q=%b expected %b", q4, e);
    end
    @(negedge clk);
    ld4  = 1'b1;
    d4   = 4'b0101;
    rst4 = 1'b1;
    sb4.push_back(4'b1010);
    @(posedge clk);
    #1;
    e = sb4.pop_front();
    total++;
    if (q4 !== e) begin
      bad++;
      $display("FAIL reset_over_load q=%b expected %b", q4, e);
    end
    @(negedge clk);
    rst4 = 1'b0;
    ld4  = 1'b0;
    t4   = 4'b0000;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1;
    rst4 = 1'b1;
    t1   = 1'b0;
    t4   = 4'b0000;
    m1   = 1'b0;
    m4   = 4'b1010;
`ifdef TFF_LOAD_EN
    ld1 = 1'b0;
    d1  = 1'b0;
    ld4 = 1'b0;
    d4  = 4'b0000;
`endif
    test_reset();
    test_toggle_seq();
    test_random();
    test_async_reset();
    test_multibit();
    test_reset_coincide();
`ifdef TFF_LOAD_EN
    test_load();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
